// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC owner and byte-serial big-endian instruction fetch
module inst_fetch_unit #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              FetchReq,
    input  logic              PCWre,
    input  logic [31:0]       NextPC,
    output logic [31:0]       PC,
    output logic              Busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [31:0]       instruction,
    output logic              IRWre
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [1:0]          r_cnt;
    logic [ADDR_W-3:0]   r_base;
    logic [31:0]         r_pc;
    logic [31:0]         r_instr;
    logic                r_irwre;
    logic [ADDR_W-3:0]   w_fetch_word;

    // A PC load in the same cycle as a fetch request redirects that fetch.
    assign w_fetch_word = PCWre ? NextPC[ADDR_W-1:2] : r_pc[ADDR_W-1:2];

    // Next-state decode: four read cycles, one drain for the last byte, one done strobe.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (FetchReq) w_next_state = S_FETCH;
            S_FETCH: if (r_cnt == 2'd3) w_next_state = S_DRAIN;
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC, fetch base, byte counter and instruction assembly.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_pc    <= RESET_PC;
            r_cnt   <= 2'd0;
            r_base  <= '0;
            r_instr <= 32'h0000_0000;
            r_irwre <= 1'b0;
        end else begin
            r_irwre <= (r_state == S_DRAIN);
            case (r_state)
                S_IDLE: begin
                    if (PCWre) begin
                        r_pc <= NextPC;
                    end
                    if (FetchReq) begin
                        r_base <= w_fetch_word;
                        r_cnt  <= 2'd0;
                    end
                end
                S_FETCH: begin
                    r_cnt <= r_cnt + 2'd1;
                    // Memory data lags the address by one cycle, so byte cnt-1 lands now.
                    case (r_cnt)
                        2'd1:    r_instr[31:24] <= mem_data;
                        2'd2:    r_instr[23:16] <= mem_data;
                        2'd3:    r_instr[15:8]  <= mem_data;
                        default: ;
                    endcase
                end
                S_DRAIN: begin
                    r_instr[7:0] <= mem_data;
                end
                default: ;
            endcase
        end
    end

    assign PC          = r_pc;
    assign instruction = r_instr;
    assign IRWre       = r_irwre;
    assign Busy        = (r_state != S_IDLE);
    assign mem_rd      = (r_state == S_FETCH);
    assign mem_addr    = (r_state == S_FETCH) ? {r_base, r_cnt} : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic        FetchReq;
    logic        PCWre;
    logic [31:0] NextPC;
    logic [31:0] PC;
    logic        Busy;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] instruction;
    logic        IRWre;

    logic [7:0]  mem [256];

    int tests;
    int fails;

    // Results captured by run_fetch for the calling test to compare.
    logic [31:0] f_addrs;
    logic [9:0]  f_rd_bits;
    logic [9:0]  f_busy_bits;
    logic [9:0]  f_irwre_bits;
    int          f_irwre_count;
    logic [31:0] f_instr;

    inst_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0000_0000)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .FetchReq   (FetchReq),
        .PCWre      (PCWre),
        .NextPC     (NextPC),
        .PC         (PC),
        .Busy       (Busy),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .instruction(instruction),
        .IRWre      (IRWre)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered byte-wide instruction memory.
    always @(posedge CLK) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one fetch in the current cycle and observe cycles n+1..n+10.
    task automatic run_fetch(input logic pcwre, input logic [31:0] npc, input logic disturb);
        FetchReq = 1'b1;
        PCWre    = pcwre;
        NextPC   = npc;
        f_addrs = 32'h0; f_rd_bits = '0; f_busy_bits = '0; f_irwre_bits = '0;
        f_irwre_count = 0; f_instr = 32'h0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) begin FetchReq = 1'b0; PCWre = 1'b0; NextPC = 32'h0; end
            if (disturb && k == 2) begin FetchReq = 1'b1; PCWre = 1'b1; NextPC = 32'h40; end
            if (disturb && k == 3) begin FetchReq = 1'b0; PCWre = 1'b0; NextPC = 32'h0; end
            f_rd_bits[k-1]   = mem_rd;
            f_busy_bits[k-1] = Busy;
            f_irwre_bits[k-1] = IRWre;
            if (k <= 4) f_addrs[31-8*(k-1) -: 8] = mem_addr;
            if (IRWre) begin f_irwre_count++; f_instr = instruction; end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; FetchReq = 1'b0; PCWre = 1'b0; NextPC = 32'h0;
        step(); step();
        tests++; if (PC !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want %h", PC, 32'h0); end
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want %h", instruction, 32'h0); end
        tests++; if ({IRWre, mem_rd, Busy} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b want 000", {IRWre, mem_rd, Busy}); end
        tests++; if (mem_addr !== 8'h0) begin fails++; $display("FAIL reset_addr: got %h want 00", mem_addr); end
        Reset = 1'b0;
        step();
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", Busy); end
    endtask

    task automatic test_basic_fetch();
        run_fetch(1'b0, 32'h0, 1'b0);
        tests++; if (f_addrs !== 32'h00010203) begin fails++; $display("FAIL basic_addrs: got %h want 00010203", f_addrs); end
        tests++; if (f_rd_bits !== 10'b0000001111) begin fails++; $display("FAIL basic_rd: got %b want 0000001111", f_rd_bits); end
        tests++; if (f_irwre_bits !== 10'b0000100000) begin fails++; $display("FAIL basic_irwre: got %b want 0000100000", f_irwre_bits); end
        tests++; if (f_instr !== 32'h8C010004) begin fails++; $display("FAIL basic_instr: got %h want 8c010004", f_instr); end
        tests++; if (instruction !== 32'h8C010004) begin fails++; $display("FAIL basic_hold: got %h want 8c010004", instruction); end
        tests++; if (PC !== 32'h0) begin fails++; $display("FAIL basic_pc: got %h want 0", PC); end
    endtask

    task automatic test_pc_load_fetch();
        run_fetch(1'b1, 32'h10, 1'b0);
        tests++; if (PC !== 32'h10) begin fails++; $display("FAIL load_pc: got %h want 00000010", PC); end
        tests++; if (f_addrs !== 32'h10111213) begin fails++; $display("FAIL load_addrs: got %h want 10111213", f_addrs); end
        tests++; if (f_instr !== 32'h4A4B4849) begin fails++; $display("FAIL load_instr: got %h want 4a4b4849", f_instr); end
    endtask

    task automatic test_wrap();
        PCWre = 1'b1; NextPC = 32'h000000FE;
        step();
        PCWre = 1'b0; NextPC = 32'h0;
        tests++; if (PC !== 32'hFE) begin fails++; $display("FAIL wrap_pcload: got %h want 000000fe", PC); end
        run_fetch(1'b0, 32'h0, 1'b0);
        tests++; if (f_addrs !== 32'hFCFDFEFF) begin fails++; $display("FAIL align_addrs: got %h want fcfdfeff", f_addrs); end
        tests++; if (f_instr !== 32'hA6A7A4A5) begin fails++; $display("FAIL align_instr: got %h want a6a7a4a5", f_instr); end
        run_fetch(1'b1, 32'h00000104, 1'b0);
        tests++; if (f_addrs !== 32'h04050607) begin fails++; $display("FAIL wrap_addrs: got %h want 04050607", f_addrs); end
        tests++; if (f_instr !== 32'h5E5F5C5D) begin fails++; $display("FAIL wrap_instr: got %h want 5e5f5c5d", f_instr); end
        tests++; if (PC !== 32'h104) begin fails++; $display("FAIL wrap_pc: got %h want 00000104", PC); end
    endtask

    task automatic test_busy_ignore();
        run_fetch(1'b0, 32'h0, 1'b1);
        tests++; if (f_irwre_count !== 1) begin fails++; $display("FAIL busy_irwre_count: got %0d want 1", f_irwre_count); end
        tests++; if (PC !== 32'h104) begin fails++; $display("FAIL busy_pc: got %h want 00000104", PC); end
        tests++; if (f_rd_bits !== 10'b0000001111) begin fails++; $display("FAIL busy_rd: got %b want 0000001111", f_rd_bits); end
        tests++; if (f_addrs !== 32'h04050607) begin fails++; $display("FAIL busy_addrs: got %h want 04050607", f_addrs); end
    endtask

    task automatic test_back_to_back();
        run_fetch(1'b1, 32'h0, 1'b0);
        tests++; if (f_busy_bits !== 10'b0000111111) begin fails++; $display("FAIL b2b_busy: got %b want 0000111111", f_busy_bits); end
        tests++; if (f_instr !== 32'h8C010004) begin fails++; $display("FAIL b2b_instr0: got %h want 8c010004", f_instr); end
        run_fetch(1'b1, 32'h10, 1'b0);
        tests++; if (f_instr !== 32'h4A4B4849) begin fails++; $display("FAIL b2b_instr1: got %h want 4a4b4849", f_instr); end
    endtask

    task automatic test_reset_mid();
        int irw;
        irw = 0;
        FetchReq = 1'b1;
        step();
        FetchReq = 1'b0;
        step(); step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", Busy); end
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL mid_instr: got %h want 0", instruction); end
        tests++; if (mem_rd !== 1'b0) begin fails++; $display("FAIL mid_rd: got %b want 0", mem_rd); end
        tests++; if (PC !== 32'h0) begin fails++; $display("FAIL mid_pc: got %h want 0", PC); end
        if (IRWre) irw++;
        for (int k = 0; k < 8; k++) begin
            step();
            if (IRWre) irw++;
        end
        tests++; if (irw !== 0) begin fails++; $display("FAIL mid_irwre: got %0d pulses want 0", irw); end
    endtask

    initial begin
        tests = 0; fails = 0;
        mem_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
        Reset = 1'b1; FetchReq = 1'b0; PCWre = 1'b0; NextPC = 32'h0;
        test_reset();
        test_basic_fetch();
        test_pc_load_fetch();
        test_wrap();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Producer side of the instruction-register path in the multi-cycle MIPS core. It owns the PC, reads one 32-bit instruction from a byte-wide, registered instruction memory over four reads, and assembles the word big-endian. It then presents the word on `instruction` together with a one-cycle `IRWre` strobe, so the instruction register latches it. The control unit requests fetches and loads new PC values.

Parameters:
ADDR_W, 8, instruction-memory byte-address width (memory depth 2^ADDR_W bytes)
RESET_PC, 32'h00000000, PC value after reset

Ports:
CLK  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
FetchReq  input  1  control unit requests a fetch at current PC; sampled only in IDLE
PCWre  input  1  load NextPC into PC; honoured only in IDLE
NextPC  input  32  next PC value from PC-select logic
PC  output  32  current PC register
Busy  output  1  high whenever state != IDLE
mem_rd  output  1  instruction-memory read enable
mem_addr  output  ADDR_W  instruction-memory byte address
mem_data  input  8  read data; valid the cycle after the cycle in which mem_rd=1 with that address
instruction  output  32  assembled instruction; holds the last value between fetches
IRWre  output  1  one-cycle pulse; instruction is valid and stable in that cycle

Behaviour:
- Reset (any state, abandons any fetch in progress):
  - PC=RESET_PC, state=IDLE, cnt=0, instruction=0.
  - IRWre=0, mem_rd=0, mem_addr=0, Busy=0.
- States and transitions:
  - IDLE -> FETCH on FetchReq=1.
  - FETCH (cnt 0..3) -> DRAIN when cnt=3.
  - DRAIN -> DONE.
  - DONE -> IDLE unconditionally.
- IDLE, on each edge:
  - If PCWre=1: PC<=NextPC.
  - If FetchReq=1: base<=(PCWre ? NextPC : PC), cnt<=0, go to FETCH.
  - When both are high, the new PC is used for the fetch.
- FETCH:
  - mem_rd=1, mem_addr={base[ADDR_W-1:2], cnt[1:0]}.
  - PC[1:0] is ignored (forced word alignment). Upper PC bits above ADDR_W are truncated, so addresses wrap modulo 2^ADDR_W.
  - At each edge: cnt<=cnt+1.
  - At each edge with cnt>=1, byte (cnt-1) is captured from mem_data.
- DRAIN:
  - mem_rd=0.
  - Byte 3 is captured at the end of this cycle.
- Byte placement (big-endian):
  - byte0 -> instruction[31:24], byte1 -> [23:16], byte2 -> [15:8], byte3 -> [7:0].
  - Bytes are written directly into the instruction register. Intermediate values are visible while Busy=1, but consumers must only sample on IRWre.
- DONE: IRWre=1 for exactly this cycle; instruction is complete.
- Latency: FetchReq sampled high at the end of cycle n gives:
  - mem_rd high in cycles n+1..n+4, with addresses base+0..base+3;
  - IRWre high in cycle n+6 only.
  - Back-to-back: the earliest next acceptance is at the end of cycle n+7 (IDLE).
- FetchReq while Busy: ignored, not queued.
- PCWre while Busy: ignored; PC and base stay stable through the fetch.
- PC does not auto-increment; PC+4 arrives via NextPC/PCWre from the datapath.
- Outputs are registered, except that mem_rd, mem_addr and Busy decode from registered state.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles with FetchReq=0 -> PC=0, instruction=0, IRWre=0, mem_rd=0, Busy=0.
- Basic fetch: memory bytes 0..3 = 8C,01,00,04; FetchReq pulse at cycle n ->
  - mem_addr 0,1,2,3 in cycles n+1..n+4;
  - IRWre=1 only in cycle n+6, instruction=32'h8C010004;
  - instruction holds afterwards.
- PC load plus simultaneous fetch: in IDLE, PCWre=1, NextPC=32'h00000010, FetchReq=1 ->
  - PC=0x10, mem_addr 0x10..0x13;
  - instruction equals the bytes at 0x10..0x13.
- Alignment and wrap: PC=32'h000000FE with ADDR_W=8 -> mem_addr FC,FD,FE,FF.
  - PC=32'h00000104 -> mem_addr 04..07.
- Ignored requests while Busy: FetchReq and PCWre (NextPC=0x40) pulsed during FETCH ->
  - exactly one IRWre;
  - PC unchanged;
  - no second fetch starts.
- Reset mid-fetch: Reset=1 in cycle n+3 ->
  - next cycle IDLE, instruction=0, mem_rd=0;
  - no IRWre pulse ever occurs for the abandoned fetch.
